// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch path.
package riscv_pkg;

    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Response-timeout counter: expired pulses in the cycle that would be the
// TIMEOUT_CYCLES-th enabled cycle since the last clear.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && cnt != LIMIT)
            cnt <= cnt + 1'b1;
    end

    // Combinational so the owner can still let same-cycle data win.
    assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Program-counter owner of the single-cycle RV32I core: one fetch at a time
// over req/gnt/rvalid, present instruction to execute, retire on next-PC.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [ILEN-1:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [ILEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic [ILEN-1:0] iaddr,
    output logic [ILEN-1:0] idata,
    output logic            instr_valid,
    input  logic [ILEN-1:0] iaddr_val,
    input  logic            iaddr_val_valid,
    input  logic            stall,
    output logic [31:0]     instret,
    output logic            misalign_err,
    output logic            bus_err
);

    fetch_state_t    state_q, state_d;
    logic [ILEN-1:0] pc_q, idata_q;
    logic [31:0]     instret_q;
    logic            misalign_q, bus_err_q;
    logic            tmr_clear, tmr_enable, tmr_expired;
    logic            retire, misaligned;

    assign tmr_clear  = (state_q == REQ) && imem_gnt;
    assign tmr_enable = (state_q == WAIT) && !imem_rvalid;
    assign retire     = (state_q == EXEC) && iaddr_val_valid && !stall;
    assign misaligned = iaddr_val[1:0] != 2'b00;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = REQ;
            REQ:   if (imem_gnt) state_d = WAIT;
            WAIT: begin
                if (imem_rvalid)      state_d = EXEC;
                else if (tmr_expired) state_d = FAULT;
            end
            EXEC:  if (retire) state_d = misaligned ? FAULT : REQ;
            FAULT: state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            idata_q    <= '0;
            instret_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT && imem_rvalid)
                idata_q <= imem_rdata;
            if (state_q == WAIT && !imem_rvalid && tmr_expired)
                bus_err_q <= 1'b1;
            if (retire && misaligned)
                misalign_q <= 1'b1;
            if (retire && !misaligned) begin
                pc_q      <= iaddr_val;
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Address tracks pc in every state, so it is trivially stable while ungranted.
    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign iaddr        = pc_q;
    assign idata        = idata_q;
    assign instr_valid  = (state_q == EXEC);
    assign instret      = instret_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; inputs driven and outputs sampled on negedge.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] iaddr;
    logic [31:0] idata;
    logic        instr_valid;
    logic [31:0] iaddr_val;
    logic        iaddr_val_valid;
    logic        stall;
    logic [31:0] instret;
    logic        misalign_err;
    logic        bus_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .iaddr(iaddr), .idata(idata), .instr_valid(instr_valid),
        .iaddr_val(iaddr_val), .iaddr_val_valid(iaddr_val_valid), .stall(stall),
        .instret(instret), .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        iaddr_val = 0; iaddr_val_valid = 0; stall = 0;
        cyc(2);
        rst = 1'b0;
        cyc(1); // IDLE -> REQ
    endtask

    // REQ (granted at once) -> WAIT -> EXEC with the given word.
    task automatic fetch(input logic [31:0] word);
        imem_gnt = 1; cyc(1);
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = word; cyc(1);
        imem_rvalid = 0; imem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        iaddr_val = 0; iaddr_val_valid = 0; stall = 0;
        cyc(2);
        n_cmp++; if ({imem_req, instr_valid, misalign_err, bus_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags got %b want 0000", {imem_req, instr_valid, misalign_err, bus_err}); end
        n_cmp++; if ({iaddr, idata, instret} !== 96'h0) begin
            n_err++; $display("FAIL reset_regs got iaddr=%h idata=%h instret=%h want 0", iaddr, idata, instret); end
        rst = 1'b0; cyc(1);
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL idle_to_req got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        imem_gnt = 1; cyc(1);
        n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL wait_state got req=%b iv=%b want 0/0", imem_req, instr_valid); end
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013; cyc(1);
        imem_rvalid = 0; imem_rdata = 32'hFFFF_FFFF;
        n_cmp++; if (instr_valid !== 1'b1 || idata !== 32'h0000_0013 || iaddr !== 32'h0) begin
            n_err++; $display("FAIL exec_present got iv=%b idata=%h iaddr=%h want 1/00000013/0", instr_valid, idata, iaddr); end
        iaddr_val = 32'h4; iaddr_val_valid = 1; cyc(1);
        iaddr_val_valid = 0;
        n_cmp++; if (iaddr !== 32'h4 || instret !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_err++; $display("FAIL retire got pc=%h instret=%0d req=%b addr=%h want 4/1/1/4", iaddr, instret, imem_req, imem_addr); end
    endtask

    task automatic test_gnt_hold();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                n_err++; $display("FAIL gnt_hold[%0d] got req=%b addr=%h want 1/0", i, imem_req, imem_addr); end
        end
        // rvalid in REQ must be ignored
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc(1);
        imem_rvalid = 0;
        n_cmp++; if (imem_req !== 1'b1 || idata !== 32'h0) begin
            n_err++; $display("FAIL rvalid_in_req got req=%b idata=%h want 1/0", imem_req, idata); end
        fetch(32'h0000_0033);
        n_cmp++; if (instr_valid !== 1'b1 || idata !== 32'h0000_0033) begin
            n_err++; $display("FAIL gnt_late_fetch got iv=%b idata=%h want 1/00000033", instr_valid, idata); end
    endtask

    task automatic test_stall();
        apply_reset();
        fetch(32'h0000_006F);
        stall = 1; iaddr_val = 32'h8; iaddr_val_valid = 1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            n_cmp++; if (instr_valid !== 1'b1 || iaddr !== 32'h0 || instret !== 32'd0 || idata !== 32'h0000_006F) begin
                n_err++; $display("FAIL stall[%0d] got iv=%b pc=%h instret=%0d idata=%h", i, instr_valid, iaddr, instret, idata); end
        end
        stall = 0; cyc(1);
        iaddr_val_valid = 0;
        n_cmp++; if (iaddr !== 32'h8 || instret !== 32'd1 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL stall_release got pc=%h instret=%0d req=%b want 8/1/1", iaddr, instret, imem_req); end
    endtask

    task automatic test_instret_wrap();
        apply_reset();
        fetch(32'h0000_0013);
        force dut.instret_q = 32'hFFFF_FFFF;
        cyc(1);
        release dut.instret_q;
        cyc(1);
        n_cmp++; if (instret !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL preload got %h want ffffffff", instret); end
        iaddr_val = 32'h0; iaddr_val_valid = 1; cyc(1);
        iaddr_val_valid = 0;
        n_cmp++; if (instret !== 32'h0 || iaddr !== 32'h0 || misalign_err !== 1'b0) begin
            n_err++; $display("FAIL instret_wrap got instret=%h pc=%h me=%b want 0/0/0", instret, iaddr, misalign_err); end
    endtask

    task automatic test_misalign();
        apply_reset();
        fetch(32'h0000_0013);
        iaddr_val = 32'h10; iaddr_val_valid = 1; cyc(1);
        iaddr_val_valid = 0;
        fetch(32'h0000_0063);
        iaddr_val = 32'h0000_0102; iaddr_val_valid = 1; cyc(1);
        iaddr_val_valid = 0;
        n_cmp++; if (misalign_err !== 1'b1 || bus_err !== 1'b0) begin
            n_err++; $display("FAIL misalign_flag got me=%b be=%b want 1/0", misalign_err, bus_err); end
        n_cmp++; if (iaddr !== 32'h10 || instret !== 32'd1) begin
            n_err++; $display("FAIL misalign_state got pc=%h instret=%0d want 10/1", iaddr, instret); end
        imem_gnt = 1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            n_cmp++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b1) begin
                n_err++; $display("FAIL fault_hold[%0d] got req=%b iv=%b me=%b want 0/0/1", i, imem_req, instr_valid, misalign_err); end
        end
        imem_gnt = 0;
    endtask

    task automatic test_rvalid_at_limit();
        apply_reset();
        imem_gnt = 1; cyc(1);
        imem_gnt = 0;
        cyc(15);
        n_cmp++; if (bus_err !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL wait15 got be=%b iv=%b want 0/0", bus_err, instr_valid); end
        imem_rvalid = 1; imem_rdata = 32'h1234_5678; cyc(1);
        imem_rvalid = 0;
        n_cmp++; if (bus_err !== 1'b0 || instr_valid !== 1'b1 || idata !== 32'h1234_5678) begin
            n_err++; $display("FAIL rvalid_at_limit got be=%b iv=%b idata=%h want 0/1/12345678", bus_err, instr_valid, idata); end
    endtask

    task automatic test_bus_err();
        apply_reset();
        imem_gnt = 1; cyc(1);
        imem_gnt = 0;
        cyc(15);
        n_cmp++; if (bus_err !== 1'b0) begin
            n_err++; $display("FAIL bus_err_early got %b want 0", bus_err); end
        cyc(1);
        n_cmp++; if (bus_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++; $display("FAIL bus_err got be=%b req=%b iv=%b want 1/0/0", bus_err, imem_req, instr_valid); end
        imem_rvalid = 1; imem_rdata = 32'hAAAA_5555; cyc(2);
        imem_rvalid = 0;
        n_cmp++; if (bus_err !== 1'b1 || instr_valid !== 1'b0 || idata !== 32'h0) begin
            n_err++; $display("FAIL bus_err_sticky got be=%b iv=%b idata=%h want 1/0/0", bus_err, instr_valid, idata); end
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        fetch(32'h0000_0013);
        iaddr_val = 32'h20; iaddr_val_valid = 1; cyc(1);
        iaddr_val_valid = 0;
        imem_gnt = 1; cyc(1);
        imem_gnt = 0;
        #2 rst = 1'b1; #1;
        n_cmp++; if (iaddr !== 32'h0 || imem_req !== 1'b0 || instret !== 32'd0 || idata !== 32'h0) begin
            n_err++; $display("FAIL async_reset got pc=%h req=%b instret=%0d idata=%h", iaddr, imem_req, instret, idata); end
        cyc(1);
        rst = 1'b0; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; cyc(2);
        imem_rvalid = 0;
        n_cmp++; if (idata !== 32'h0 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_err++; $display("FAIL late_rvalid got idata=%h iv=%b req=%b addr=%h want 0/0/1/0", idata, instr_valid, imem_req, imem_addr); end
        fetch(32'h0000_0093);
        n_cmp++; if (instr_valid !== 1'b1 || idata !== 32'h0000_0093 || iaddr !== 32'h0) begin
            n_err++; $display("FAIL fresh_fetch got iv=%b idata=%h pc=%h want 1/00000093/0", instr_valid, idata, iaddr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_gnt_hold();
        test_stall();
        test_instret_wrap();
        test_misalign();
        test_rvalid_at_limit();
        test_bus_err();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Owns the architectural program counter of the single-cycle RV32I core.
- Fetches each instruction from instruction memory over a req/gnt/rvalid handshake and presents the PC and instruction word to the decode/execute units (B/J/I/R/U types).
- Accepts the next-PC value those units compute and retires the instruction.
- Closes the loop opposite the branch unit: the branch unit consumes iaddr/idata and produces iaddr_val; this block produces iaddr/idata and consumes iaddr_val.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for imem_rvalid after a grant before declaring a bus error.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  instruction word.
- iaddr  out  32  PC of the instruction being executed.
- idata  out  32  instruction word being executed.
- instr_valid  out  1  iaddr/idata valid for execute units.
- iaddr_val  in  32  next PC from the execute units.
- iaddr_val_valid  in  1  execute result ready; retire request.
- stall  in  1  hold the current instruction; blocks retirement.
- instret  out  32  retired-instruction counter.
- misalign_err  out  1  sticky; next PC was not word-aligned.
- bus_err  out  1  sticky; response timeout.

Behaviour:
- Reset (async, immediate):
  - pc=RESET_VECTOR, state=IDLE.
  - imem_req=0, instr_valid=0, idata=0, instret=0, misalign_err=0, bus_err=0.
  - iaddr always equals pc, so it reads RESET_VECTOR.
- State machine:
  - IDLE: one cycle after reset release, then go to REQ.
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt, clear the timer and go to WAIT. Otherwise hold; imem_addr must stay stable while not granted.
  - WAIT: imem_req=0.
    - On imem_rvalid: idata<=imem_rdata, go to EXEC.
    - Otherwise the timer increments. If it reaches TIMEOUT_CYCLES without rvalid: bus_err<=1, go to FAULT.
    - rvalid arriving in the same cycle the timer reaches its limit is accepted; the data wins.
  - EXEC: instr_valid=1.
    - If iaddr_val_valid && !stall && iaddr_val[1:0]!=0: misalign_err<=1, go to FAULT; pc and instret are unchanged.
    - If iaddr_val_valid && !stall and aligned: pc<=iaddr_val, instret<=instret+1, go to REQ.
    - If stall=1: hold everything; iaddr_val_valid is ignored.
  - FAULT: imem_req=0, instr_valid=0. Held until reset; error flags stay set.
- Latency:
  - Minimum 3 cycles per instruction: REQ granted in its first cycle, rvalid in the first WAIT cycle, retire in the first EXEC cycle.
  - No overlap of fetches; exactly one outstanding request.
- Arithmetic:
  - instret wraps modulo 2^32 (0xFFFF_FFFF -> 0) with no flag.
  - pc wraps naturally; iaddr_val=0 is legal.
- Protocol rules:
  - imem_rvalid outside WAIT is ignored.
  - imem_gnt outside REQ is ignored.
  - idata is stable throughout EXEC.
- Reset mid-operation: an outstanding request is abandoned; a late rvalid after reset arrives in IDLE/REQ and is discarded.

Decomposition:
- riscv_pkg gains:
  - fetch_state_t enum {IDLE, REQ, WAIT, EXEC, FAULT}.
  - Constant ILEN=32.
  - Default RESET_VECTOR constant.
- Sub-module fetch_timeout_ctr:
  - Inputs: clear, enable.
  - Output: expired.
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Same async active-high reset.

Test Plan:
- Reset release, gnt same cycle, rvalid next cycle with rdata=32'h0000_0013, iaddr_val=4 -> instr_valid high on cycle 3, pc=4, instret=1, imem_addr=4 on next REQ.
- Hold gnt low 5 cycles in REQ -> imem_req stays 1 and imem_addr stays 0; no state change until gnt.
- Branch retire with iaddr_val=32'h0000_0102 -> misalign_err=1, FAULT, imem_req=0 forever, pc unchanged, instret unchanged.
- No rvalid for 16 cycles after gnt -> bus_err=1 and FAULT; rvalid on cycle 16 instead -> idata latched, no error.
- stall=1 for 3 cycles with iaddr_val_valid=1 and iaddr_val=8 -> no retire; after stall drops -> pc=8, instret increments once.
- Preload instret via 2^32 retires (force/backdoor) -> wraps to 0. Assert rst in WAIT, then deliver rvalid -> discarded, pc=RESET_VECTOR, fresh fetch.
